// File: rtl/slice_seq_pkg.sv
// Shared types and constants for the bit-slice op sequencer.
// Command ops, datapath mode encodings and sequencer FSM states.
package slice_seq_pkg;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUT     = 3'd4
  } state_e;

  localparam logic [3:0] MODE_IDLE = 4'h0;
  localparam logic [3:0] MODE_ADD  = 4'h1;
  localparam logic [3:0] MODE_SUB  = 4'h2;
  localparam logic [3:0] MODE_OVR  = 4'hF;

  function automatic logic [3:0] mode_of(input op_e op);
    logic [3:0] m;
    case (op)
      OP_PASS: m = MODE_IDLE;
      OP_ADD:  m = MODE_ADD;
      OP_SUB:  m = MODE_SUB;
      OP_CLR:  m = MODE_OVR;
      default: m = MODE_IDLE;
    endcase
    return m;
  endfunction

  // SUB seeds a carry of 1 to complete the two's-complement subtract.
  function automatic logic first_cin(input op_e op, input logic cin);
    logic c;
    case (op)
      OP_ADD:  c = cin;
      OP_SUB:  c = 1'b1;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/slice_step_ctr.sv
// Step counter for the sequencer: tracks the entry index within a command,
// produces the wrapped operand select (base+idx) and the last-step flag.
module slice_step_ctr
  import slice_seq_pkg::*;
#(
  parameter int SEL_W = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             adv,
  input  logic             clr,
  input  logic [SEL_W-1:0] base,
  input  logic [LEN_W-1:0] len,
  output logic [SEL_W-1:0] sel,
  output logic             last
);

  localparam logic [LEN_W-1:0] IDX_ONE = LEN_W'(1'b1);

  logic [SEL_W-1:0] base_r;
  logic [SEL_W-1:0] sel_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] idx_r;
  logic             last_r;
  logic [LEN_W-1:0] idx_nx_s;

  assign idx_nx_s = idx_r + IDX_ONE;

  // Index, select and last flag; select arithmetic wraps at 2**SEL_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r <= '0;
      len_r  <= '0;
      idx_r  <= '0;
      sel_r  <= '0;
      last_r <= 1'b0;
    end else if (load) begin
      base_r <= base;
      len_r  <= len;
      idx_r  <= '0;
      sel_r  <= base;
      last_r <= (len == '0);
    end else if (adv) begin
      idx_r  <= idx_nx_s;
      sel_r  <= base_r + SEL_W'(idx_nx_s);
      last_r <= (idx_nx_s == len_r);
    end else if (clr) begin
      idx_r  <= '0;
      sel_r  <= '0;
      last_r <= 1'b0;
    end else begin
      idx_r  <= idx_r;
      sel_r  <= sel_r;
      last_r <= last_r;
    end
  end

  assign sel  = sel_r;
  assign last = last_r;

endmodule

// File: rtl/slice_op_sequencer.sv
// Walks the bit-slice datapath through cmd_len+1 entries, one slice op per
// entry, chaining the carry and streaming result bits out with valid/ready.
module slice_op_sequencer
  import slice_seq_pkg::*;
#(
  parameter int DP_LAT = 1,
  parameter int SEL_W  = 4,
  parameter int LEN_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [SEL_W-1:0] cmd_base,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_cin,
  output logic [SEL_W-1:0] dp_sel,
  output logic [3:0]       dp_mode,
  output logic             dp_bypass,
  output logic             dp_kill,
  output logic             dp_cin,
  input  logic             dp_sum,
  input  logic             dp_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_bit,
  output logic             res_last,
  output logic             carry_out,
  output logic             busy
);

  localparam logic [1:0] WAIT_LAST = 2'((DP_LAT >= 2) ? (DP_LAT - 2) : 0);

  state_e     state_r, state_nx_s;
  op_e        op_r;
  op_e        cmd_op_s;
  logic       cout_r;
  logic [1:0] wait_r;
  logic       last_s;
  logic       accept_s, hs_s, adv_s, done_s;

  logic       cmd_ready_r, busy_r, dp_kill_r, dp_bypass_r, dp_cin_r;
  logic [3:0] dp_mode_r;
  logic       res_valid_r, res_bit_r, res_last_r, carry_out_r;

  logic       cmd_ready_nx_s, busy_nx_s, dp_kill_nx_s, dp_bypass_nx_s, dp_cin_nx_s;
  logic [3:0] dp_mode_nx_s;
  logic       res_valid_nx_s, res_bit_nx_s, res_last_nx_s, carry_out_nx_s;

  assign cmd_op_s = op_e'(cmd_op);
  assign accept_s = (state_r == ST_IDLE) && cmd_valid && cmd_ready_r;
  assign hs_s     = (state_r == ST_OUT) && res_ready;
  assign adv_s    = hs_s && !last_s;
  assign done_s   = hs_s && last_s;

  slice_step_ctr #(.SEL_W(SEL_W), .LEN_W(LEN_W)) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .load (accept_s),
    .adv  (adv_s),
    .clr  (done_s),
    .base (cmd_base),
    .len  (cmd_len),
    .sel  (dp_sel),
    .last (last_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:    if (accept_s) state_nx_s = ST_ISSUE; else state_nx_s = ST_IDLE;
      ST_ISSUE:   if (DP_LAT <= 1) state_nx_s = ST_CAPTURE; else state_nx_s = ST_WAIT;
      ST_WAIT:    if (wait_r == WAIT_LAST) state_nx_s = ST_CAPTURE; else state_nx_s = ST_WAIT;
      ST_CAPTURE: state_nx_s = ST_OUT;
      ST_OUT: begin
        if (hs_s) begin
          if (last_s) state_nx_s = ST_IDLE; else state_nx_s = ST_ISSUE;
        end else begin
          state_nx_s = ST_OUT;
        end
      end
      default:    state_nx_s = ST_IDLE;
    endcase
  end

  // Latency counter, latched op and the carry captured from the current step.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_r <= 2'd0;
      op_r   <= OP_PASS;
      cout_r <= 1'b0;
    end else begin
      wait_r <= (state_r == ST_WAIT) ? (wait_r + 2'd1) : 2'd0;
      if (accept_s) op_r <= cmd_op_s;
      if (state_r == ST_CAPTURE) cout_r <= (op_r == OP_CLR) ? 1'b0 : dp_cout;
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    cmd_ready_nx_s = (state_nx_s == ST_IDLE);
    busy_nx_s      = (state_nx_s != ST_IDLE);
    dp_mode_nx_s   = dp_mode_r;
    dp_bypass_nx_s = dp_bypass_r;
    dp_kill_nx_s   = dp_kill_r;
    dp_cin_nx_s    = dp_cin_r;
    res_valid_nx_s = res_valid_r;
    res_bit_nx_s   = res_bit_r;
    res_last_nx_s  = res_last_r;
    carry_out_nx_s = carry_out_r;
    if (accept_s) begin
      dp_mode_nx_s   = mode_of(cmd_op_s);
      dp_bypass_nx_s = (cmd_op_s == OP_PASS);
      dp_kill_nx_s   = (cmd_op_s == OP_CLR);
      dp_cin_nx_s    = first_cin(cmd_op_s, cmd_cin);
    end else if (state_r == ST_CAPTURE) begin
      res_valid_nx_s = 1'b1;
      res_bit_nx_s   = (op_r == OP_CLR) ? 1'b0 : dp_sum;
      res_last_nx_s  = last_s;
    end else if (adv_s) begin
      dp_cin_nx_s    = cout_r;
      res_valid_nx_s = 1'b0;
      res_bit_nx_s   = 1'b0;
      res_last_nx_s  = 1'b0;
    end else if (done_s) begin
      dp_mode_nx_s   = MODE_IDLE;
      dp_bypass_nx_s = 1'b0;
      dp_kill_nx_s   = 1'b1;
      dp_cin_nx_s    = 1'b0;
      res_valid_nx_s = 1'b0;
      res_bit_nx_s   = 1'b0;
      res_last_nx_s  = 1'b0;
      carry_out_nx_s = cout_r;
    end else begin
      res_valid_nx_s = res_valid_r;
    end
  end

  // Output registers; reset drops everything to idle values in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      dp_mode_r   <= MODE_IDLE;
      dp_bypass_r <= 1'b0;
      dp_kill_r   <= 1'b1;
      dp_cin_r    <= 1'b0;
      res_valid_r <= 1'b0;
      res_bit_r   <= 1'b0;
      res_last_r  <= 1'b0;
      carry_out_r <= 1'b0;
    end else begin
      cmd_ready_r <= cmd_ready_nx_s;
      busy_r      <= busy_nx_s;
      dp_mode_r   <= dp_mode_nx_s;
      dp_bypass_r <= dp_bypass_nx_s;
      dp_kill_r   <= dp_kill_nx_s;
      dp_cin_r    <= dp_cin_nx_s;
      res_valid_r <= res_valid_nx_s;
      res_bit_r   <= res_bit_nx_s;
      res_last_r  <= res_last_nx_s;
      carry_out_r <= carry_out_nx_s;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign dp_mode   = dp_mode_r;
  assign dp_bypass = dp_bypass_r;
  assign dp_kill   = dp_kill_r;
  assign dp_cin    = dp_cin_r;
  assign res_valid = res_valid_r;
  assign res_bit   = res_bit_r;
  assign res_last  = res_last_r;
  assign carry_out = carry_out_r;

endmodule

// File: tb/tb_slice_op_sequencer.sv
// Directed table-driven bench for slice_op_sequencer (DP_LAT=1) plus a
// DP_LAT=3 instance for the latency check.
module tb_slice_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_cin;
  logic [1:0] cmd_op;
  logic [3:0] cmd_base, cmd_len, dp_sel, dp_mode;
  logic       dp_bypass, dp_kill, dp_cin, dp_sum, dp_cout;
  logic       res_valid, res_ready, res_bit, res_last, carry_out, busy;

  logic       l3_cmd_valid, l3_cmd_ready, l3_cmd_cin;
  logic [1:0] l3_cmd_op;
  logic [3:0] l3_cmd_base, l3_cmd_len, l3_dp_sel, l3_dp_mode;
  logic       l3_dp_bypass, l3_dp_kill, l3_dp_cin, l3_dp_sum, l3_dp_cout;
  logic       l3_res_valid, l3_res_ready, l3_res_bit, l3_res_last, l3_carry_out, l3_busy;

  slice_op_sequencer #(.DP_LAT(1), .SEL_W(4), .LEN_W(4)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_cin(cmd_cin),
    .dp_sel(dp_sel), .dp_mode(dp_mode), .dp_bypass(dp_bypass), .dp_kill(dp_kill),
    .dp_cin(dp_cin), .dp_sum(dp_sum), .dp_cout(dp_cout), .res_valid(res_valid),
    .res_ready(res_ready), .res_bit(res_bit), .res_last(res_last),
    .carry_out(carry_out), .busy(busy)
  );

  slice_op_sequencer #(.DP_LAT(3), .SEL_W(4), .LEN_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .cmd_valid(l3_cmd_valid), .cmd_ready(l3_cmd_ready),
    .cmd_op(l3_cmd_op), .cmd_base(l3_cmd_base), .cmd_len(l3_cmd_len), .cmd_cin(l3_cmd_cin),
    .dp_sel(l3_dp_sel), .dp_mode(l3_dp_mode), .dp_bypass(l3_dp_bypass), .dp_kill(l3_dp_kill),
    .dp_cin(l3_dp_cin), .dp_sum(l3_dp_sum), .dp_cout(l3_dp_cout), .res_valid(l3_res_valid),
    .res_ready(l3_res_ready), .res_bit(l3_res_bit), .res_last(l3_res_last),
    .carry_out(l3_carry_out), .busy(l3_busy)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  base;
    logic [3:0]  len;
    logic        cin;
    logic        sum_v;
    logic        cout_v;
    int          stall_step;
    int          stall_cyc;
    logic [15:0] exp_bits;
    logic [15:0] exp_cin;
    logic [3:0]  exp_mode;
    logic        exp_byp;
    logic        exp_kill;
    logic        exp_carry;
  } vec_t;

  vec_t vecs [6];

  logic [15:0] got_bits, got_lasts, got_cin;
  logic [3:0]  got_sel [16];
  logic [3:0]  cap_mode;
  logic        cap_byp, cap_kill;
  int          nbits, lat;

  // Apply one command, handshake every bit (optionally stalling one step), check it.
  task automatic run_vec(input vec_t v, input string tag);
    int guard, step, stalled, extra;
    logic first, h_bit, h_last, s_cin, s_byp, s_kill;
    logic [3:0] s_sel, s_mode, e_sel;
    logic [15:0] e_last;
    got_bits = '0; got_lasts = '0; got_cin = '0; nbits = 0; lat = 0;
    s_sel = '0; s_cin = 1'b0; s_mode = '0; s_byp = 1'b0; s_kill = 1'b0;
    h_bit = 1'b0; h_last = 1'b0;
    @(negedge clk);
    dp_sum = v.sum_v; dp_cout = v.cout_v; res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = v.op; cmd_base = v.base; cmd_len = v.len; cmd_cin = v.cin;
    guard = 0;
    while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    chk({tag, " cmd_ready"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    step = 0; stalled = 0; first = 1'b1; guard = 0;
    while (step <= int'(v.len) && guard < 300) begin
      guard++;
      if (!res_valid) begin
        if (step == v.stall_step && stalled > 0 && stalled < v.stall_cyc)
          chk({tag, " stall valid"}, res_valid, 1);
        if (first) lat++;
        s_sel = dp_sel; s_cin = dp_cin; s_mode = dp_mode; s_byp = dp_bypass; s_kill = dp_kill;
        res_ready = 1'b1;
      end else begin
        first = 1'b0;
        if (step == v.stall_step && stalled < v.stall_cyc) begin
          if (stalled == 0) begin
            h_bit = res_bit; h_last = res_last;
          end else begin
            chk({tag, " hold bit"}, res_bit, h_bit);
            chk({tag, " hold last"}, res_last, h_last);
            chk({tag, " hold sel"}, dp_sel, s_sel);
          end
          res_ready = 1'b0;
          stalled++;
        end else begin
          got_sel[step]   = s_sel;
          got_cin[step]   = s_cin;
          got_bits[step]  = res_bit;
          got_lasts[step] = res_last;
          if (step == 0) begin cap_mode = s_mode; cap_byp = s_byp; cap_kill = s_kill; end
          res_ready = 1'b1;
          step++; nbits++;
        end
      end
      @(negedge clk);
    end
    e_last = 16'h0001 << v.len;
    chk({tag, " latency"}, lat, 2);
    chk({tag, " nbits"}, nbits, int'(v.len) + 1);
    chk({tag, " bits"}, got_bits, v.exp_bits);
    chk({tag, " lasts"}, got_lasts, e_last);
    chk({tag, " cin seq"}, got_cin, v.exp_cin);
    for (int k = 0; k <= int'(v.len); k++) begin
      e_sel = v.base + 4'(k);
      chk({tag, " sel"}, got_sel[k], e_sel);
    end
    chk({tag, " mode"}, cap_mode, v.exp_mode);
    chk({tag, " bypass"}, cap_byp, v.exp_byp);
    chk({tag, " kill"}, cap_kill, v.exp_kill);
    chk({tag, " carry_out"}, carry_out, v.exp_carry);
    chk({tag, " ready after"}, cmd_ready, 1);
    chk({tag, " busy after"}, busy, 0);
    extra = 0;
    repeat (3) begin
      if (res_valid) extra++;
      @(negedge clk);
    end
    chk({tag, " extra valid"}, extra, 0);
  endtask

  initial begin
    int guard, cyc, extra;
    //          op     base   len    cin   sum   cout  stl  cyc bits     cin      mode  byp   kill  carry
    vecs[0] = '{2'b01, 4'd2,  4'd3,  1'b0, 1'b1, 1'b1, -1, 0, 16'h000F, 16'h000E, 4'h1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{2'b10, 4'd0,  4'd0,  1'b0, 1'b1, 1'b0, -1, 0, 16'h0001, 16'h0001, 4'h2, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'b00, 4'd14, 4'd3,  1'b1, 1'b1, 1'b1, -1, 0, 16'h000F, 16'h000E, 4'h0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{2'b11, 4'd3,  4'd15, 1'b1, 1'b1, 1'b1, -1, 0, 16'h0000, 16'h0000, 4'hF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{2'b01, 4'd15, 4'd15, 1'b1, 1'b0, 1'b0, -1, 0, 16'h0000, 16'h0001, 4'h1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2'b01, 4'd4,  4'd2,  1'b0, 1'b1, 1'b1,  1, 5, 16'h0007, 16'h0006, 4'h1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_base = 4'd0; cmd_len = 4'd0; cmd_cin = 1'b0;
    dp_sum = 1'b0; dp_cout = 1'b0; res_ready = 1'b1;
    l3_cmd_valid = 1'b0; l3_cmd_op = 2'b00; l3_cmd_base = 4'd0; l3_cmd_len = 4'd0;
    l3_cmd_cin = 1'b0; l3_dp_sum = 1'b0; l3_dp_cout = 1'b0; l3_res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst cmd_ready", cmd_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst res_valid", res_valid, 0);
    chk("rst dp_kill", dp_kill, 1);
    chk("rst dp_mode", dp_mode, 0);
    chk("rst dp_sel", dp_sel, 0);
    chk("rst dp_bypass", dp_bypass, 0);
    chk("rst dp_cin", dp_cin, 0);
    chk("rst carry_out", carry_out, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst cmd_ready", cmd_ready, 1);

    // DP_LAT=3: ISSUE to res_valid must take 4 cycles.
    l3_cmd_valid = 1'b1; l3_cmd_op = 2'b01; l3_cmd_base = 4'd5; l3_cmd_len = 4'd0;
    l3_cmd_cin = 1'b1; l3_dp_sum = 1'b1; l3_dp_cout = 1'b1;
    chk("lat3 cmd_ready", l3_cmd_ready, 1);
    @(negedge clk);
    l3_cmd_valid = 1'b0;
    chk("lat3 dp_sel", l3_dp_sel, 5);
    chk("lat3 dp_cin", l3_dp_cin, 1);
    chk("lat3 dp_mode", l3_dp_mode, 4'h1);
    cyc = 0;
    while (!l3_res_valid && cyc < 20) begin cyc++; @(negedge clk); end
    chk("lat3 latency", cyc, 4);
    chk("lat3 res_bit", l3_res_bit, 1);
    chk("lat3 res_last", l3_res_last, 1);
    @(negedge clk);
    chk("lat3 busy after", l3_busy, 0);
    chk("lat3 carry_out", l3_carry_out, 1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset on the second step of ADD len=7 aborts the command.
    @(negedge clk);
    dp_sum = 1'b1; dp_cout = 1'b1; res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_base = 4'd0; cmd_len = 4'd7; cmd_cin = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (!res_valid && guard < 20) begin guard++; @(negedge clk); end
    chk("abort first valid", res_valid, 1);
    @(negedge clk);
    chk("abort busy step2", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort res_valid", res_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort cmd_ready", cmd_ready, 0);
    chk("abort dp_kill", dp_kill, 1);
    chk("abort dp_mode", dp_mode, 0);
    chk("abort dp_sel", dp_sel, 0);
    chk("abort dp_cin", dp_cin, 0);
    chk("abort carry_out", carry_out, 0);
    chk("abort res_last", res_last, 0);
    rst = 1'b0;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (res_valid) extra++;
    end
    chk("abort no valid", extra, 0);
    chk("abort ready again", cmd_ready, 1);
    run_vec(vecs[1], "post-abort");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
